// File: rtl/dmem_responder.sv
// Single-port 32-bit data memory responder: one request in flight, response after 1+WAIT_CYCLES cycles.
// req_ready only in IDLE; the response is held until rsp_ready, so a stalled initiator blocks new requests.
module dmem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);
    localparam int         DEPTH    = 1 << (ADDR_W - 2);
    localparam logic [3:0] LAST_CNT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic [31:0]       r_mem [DEPTH];
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic              w_accept;
    logic              w_enter_resp;
    logic              w_wr;
    logic [ADDR_W-1:0] w_addr;
    logic [1:0]        w_size;
    logic              w_signed;
    logic [31:0]       w_wdata;
    logic              w_err;
    logic [31:0]       w_word;
    logic [3:0]        w_be;
    logic [31:0]       w_lanes;
    logic [31:0]       w_merged;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    assign w_accept     = req_ready && req_valid;
    assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);

    // With zero wait states the commit edge is the acceptance edge, so the live request feeds the datapath.
    assign w_wr     = (r_state == S_IDLE) ? req_wr     : r_wr;
    assign w_addr   = (r_state == S_IDLE) ? req_addr   : r_addr;
    assign w_size   = (r_state == S_IDLE) ? req_size   : r_size;
    assign w_signed = (r_state == S_IDLE) ? req_signed : r_signed;
    assign w_wdata  = (r_state == S_IDLE) ? req_wdata  : r_wdata;

    assign w_err  = (w_size == 2'b11) || ((w_size == 2'b01) && w_addr[0]) ||
                    ((w_size == 2'b10) && (w_addr[1:0] != 2'b00));
    assign w_word = r_mem[w_addr[ADDR_W-1:2]];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (r_cnt == LAST_CNT) w_next = S_RESP;
            S_RESP:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_be    = 4'b0000;
        w_lanes = w_wdata;
        case (w_size)
            2'b00: begin
                w_be    = 4'b0001 << w_addr[1:0];
                w_lanes = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
                w_lanes = {2{w_wdata[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
        w_merged = w_word;
        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) w_merged[8*i +: 8] = w_lanes[8*i +: 8];
        end
    end

    always_comb begin
        w_byte = w_word[7:0];
        case (w_addr[1:0])
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];
        case (w_size)
            2'b00:   w_load = {{24{w_signed & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{w_signed & w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == S_WAIT) ? r_cnt + 4'd1 : 4'd0;
            if (w_enter_resp) begin
                r_err   <= w_err;
                r_rdata <= (w_err || w_wr) ? 32'd0 : w_load;
            end else if ((r_state == S_RESP) && rsp_ready) begin
                r_err   <= 1'b0;
                r_rdata <= 32'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_wr     <= req_wr;
            r_addr   <= req_addr;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_wdata  <= req_wdata;
        end
    end

    // Storage is deliberately outside reset; a reset on the commit edge still suppresses the write.
    always_ff @(posedge clk) begin
        if (rst && w_enter_resp && w_wr && !w_err) begin
            r_mem[w_addr[ADDR_W-1:2]] <= w_merged;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: WAIT_CYCLES=2 responder, with a WAIT_CYCLES=0 copy watching the same request stream.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [11:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        z_req_ready;
    logic        z_rsp_valid;
    logic        z_rsp_ready;
    logic [31:0] z_rsp_rdata;
    logic        z_rsp_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dmem_responder #(.WAIT_CYCLES(2), .ADDR_W(12)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_size(req_size),
        .req_signed(req_signed), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.WAIT_CYCLES(0), .ADDR_W(12)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(z_req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_size(req_size),
        .req_signed(req_signed), .req_wdata(req_wdata), .rsp_valid(z_rsp_valid),
        .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else n_pass++;
    endtask

    // One full transaction on the WAIT_CYCLES=2 responder; the zero-wait copy is sampled one edge after acceptance.
    task automatic txn(input string tag, input logic wr, input logic [11:0] addr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] wdata, input logic [31:0] exp_d,
                       input logic exp_e, input logic [31:0] exp_zd, input int hold);
        int lat;
        @(negedge clk);
        chk({tag, "_rdy"}, req_ready, 1);
        req_valid = 1; req_wr = wr; req_addr = addr; req_size = size;
        req_signed = sgn; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 0;
        lat = 1;
        @(negedge clk);
        chk({tag, "_z_vld"}, z_rsp_valid, 1);
        chk({tag, "_z_dat"}, z_rsp_rdata, exp_zd);
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd3);
        chk({tag, "_dat"}, rsp_rdata, exp_d);
        chk({tag, "_err"}, rsp_err, exp_e);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_vld"}, rsp_valid, 1);
            chk({tag, "_hold_dat"}, rsp_rdata, exp_d);
            chk({tag, "_hold_rdy"}, req_ready, 0);
        end
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
        @(negedge clk);
        chk({tag, "_rel_vld"}, rsp_valid, 0);
        chk({tag, "_rel_dat"}, rsp_rdata, 0);
        chk({tag, "_rel_rdy"}, req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0; req_valid = 0; req_wr = 0; req_addr = '0; req_size = 0;
        req_signed = 0; req_wdata = '0; rsp_ready = 0; z_rsp_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rdy", req_ready, 1);
        chk("reset_vld", rsp_valid, 0);
        chk("reset_dat", rsp_rdata, 0);
        chk("reset_err", rsp_err, 0);
        rst = 1;

        txn("st_w010",  1, 12'h010, 2'b10, 0, 32'h12345678, 32'h0,        0, 32'h0,        0);
        txn("ld_w010",  0, 12'h010, 2'b10, 0, 32'h0,        32'h12345678, 0, 32'h12345678, 0);
        txn("st_b013",  1, 12'h013, 2'b00, 0, 32'h000000AB, 32'h0,        0, 32'h0,        0);
        txn("ld_sb013", 0, 12'h013, 2'b00, 1, 32'h0,        32'hFFFFFFAB, 0, 32'hFFFFFFAB, 0);
        txn("ld_ub013", 0, 12'h013, 2'b00, 0, 32'h0,        32'h000000AB, 0, 32'h000000AB, 0);
        txn("ld_w010b", 0, 12'h010, 2'b10, 1, 32'h0,        32'hAB345678, 0, 32'hAB345678, 0);
        txn("ld_h011",  0, 12'h011, 2'b01, 1, 32'h0,        32'h0,        1, 32'h0,        0);
        txn("st_w012",  1, 12'h012, 2'b10, 0, 32'hFFFFFFFF, 32'h0,        1, 32'h0,        0);
        txn("ld_hold",  0, 12'h010, 2'b10, 0, 32'h0,        32'hAB345678, 0, 32'hAB345678, 5);
        chk("hold_z_rdy", z_req_ready, 1);
        txn("ld_sh012", 0, 12'h012, 2'b01, 1, 32'h0,        32'hFFFFAB34, 0, 32'hFFFFAB34, 0);
        txn("ld_uh010", 0, 12'h010, 2'b01, 0, 32'h0,        32'h00005678, 0, 32'h00005678, 0);
        txn("ld_rsv",   0, 12'h010, 2'b11, 0, 32'h0,        32'h0,        1, 32'h0,        0);
        txn("st_h016",  1, 12'h016, 2'b01, 0, 32'h1234BEEF, 32'h0,        0, 32'h0,        0);
        txn("ld_sh016", 0, 12'h016, 2'b01, 1, 32'h0,        32'hFFFFBEEF, 0, 32'hFFFFBEEF, 0);
        txn("st_w020",  1, 12'h020, 2'b10, 0, 32'h11223344, 32'h0,        0, 32'h0,        0);

        // Abort a store in WAIT; only the zero-wait copy has already committed it.
        @(negedge clk);
        req_valid = 1; req_wr = 1; req_addr = 12'h020; req_size = 2'b10; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 req_valid = 0;
        @(negedge clk);
        chk("abort_in_wait", req_ready, 0);
        rst = 0;
        @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        chk("abort_rdy", req_ready, 1);
        chk("abort_vld", rsp_valid, 0);
        chk("abort_dat", rsp_rdata, 0);
        chk("abort_err", rsp_err, 0);
        repeat (4) @(negedge clk);
        chk("abort_quiet", rsp_valid, 0);
        txn("ld_w020",  0, 12'h020, 2'b10, 0, 32'h0,        32'h11223344, 0, 32'hDEADBEEF, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2, number of wait-state cycles between request acceptance and response (legal 0..15).
REQ-002 Parameter: ADDR_W, default 12, byte-address width (4 KB store, 1024 x 32-bit words).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-low.
REQ-005 Port: req_valid  input  1  initiator presents a request.
REQ-006 Port: req_ready  output  1  responder can accept a request this cycle.
REQ-007 Port: req_wr  input  1  1 = store, 0 = load.
REQ-008 Port: req_addr  input  ADDR_W  byte address.
REQ-009 Port: req_size  input  2  00 byte, 01 halfword, 10 word; 11 reserved, treated as error.
REQ-010 Port: req_signed  input  1  sign-extend byte/half load data when 1, zero-extend when 0.
REQ-011 Port: req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-012 Port: rsp_valid  output  1  response available.
REQ-013 Port: rsp_ready  input  1  initiator consumes response.
REQ-014 Port: rsp_rdata  output  32  load data, extended per size/signed; 0 for stores and errors.
REQ-015 Port: rsp_err  output  1  misaligned or reserved-size request.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 Acceptance SHALL occur on an edge where req_valid=1 and req_ready=1; wr, addr, size, signed, wdata SHALL be latched at that edge; req inputs SHALL be ignored at all other times.
REQ-018 On acceptance the FSM SHALL go to WAIT with the wait counter at 0 if WAIT_CYCLES>0, else directly to RESP.
REQ-019 In WAIT the counter SHALL increment each cycle; on the edge where counter = WAIT_CYCLES-1 the FSM SHALL enter RESP.
REQ-020 Latency: request accepted in cycle N SHALL give rsp_valid=1 first in cycle N+1+WAIT_CYCLES.
REQ-021 Error: size=01 with addr[0]=1, size=10 with addr[1:0]!=0, or size=11 SHALL set rsp_err=1, rsp_rdata=0, and suppress any memory write; the error request still takes the full latency.
REQ-022 Byte lanes little-endian: addr[1:0]=0 selects bits [7:0], 3 selects [31:24]; half at addr[1]=0 selects [15:0], addr[1]=1 selects [31:16].
REQ-023 Store SHALL modify only the addressed byte lanes, committing on the edge entering RESP.
REQ-024 Load data SHALL be read and registered into rsp_rdata on the edge entering RESP; word loads ignore req_signed.
REQ-025 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until an edge with rsp_ready=1, which returns the FSM to IDLE and clears rsp_valid, rsp_rdata and rsp_err to 0.
REQ-026 No request SHALL be accepted in the RESP-to-IDLE cycle; back-to-back throughput is one request per 2+WAIT_CYCLES cycles minimum.
REQ-027 Memory word index SHALL be addr[ADDR_W-1:2]; addresses wrap within the 4 KB store.

Reset
REQ-028 rst=0 at a clock edge SHALL force IDLE, counter 0, req_ready=1 after the edge, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-029 Reset mid-WAIT or mid-RESP SHALL abort the transaction; a pending store SHALL NOT be committed unless its commit edge has already passed.
REQ-030 Reset SHALL NOT clear memory contents.

Verification
REQ-031 WAIT_CYCLES=2: store word 0x12345678 at 0x010, then load word at 0x010 -> rsp_valid in cycle N+3, rsp_rdata=0x12345678, rsp_err=0.
REQ-032 Store byte 0xAB at 0x013, then load signed byte at 0x013 -> 0xFFFFFFAB; unsigned -> 0x000000AB; word at 0x010 -> 0xAB345678.
REQ-033 Load half at 0x011 -> rsp_err=1, rsp_rdata=0; store word 0xFFFFFFFF at 0x012 -> rsp_err=1, word at 0x010 unchanged.
REQ-034 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable and req_ready=0 throughout; rsp_ready=1 -> rsp_valid=0 next cycle, req_ready=1.
REQ-035 Assert rst=0 during WAIT of store 0xDEADBEEF to 0x020 -> IDLE, outputs 0 after the edge, later load of 0x020 returns the prior value.
REQ-036 WAIT_CYCLES=0: load accepted in cycle N -> rsp_valid=1 in cycle N+1.
